uart_tx_arbiter: RTL and testbench

- Round-robin, packet-locked arbiter that shares one `uart_tx` serializer among NUM_REQ byte-stream requesters (debug console, status reporter, etc.).
- Accepts bytes over a valid/ready interface per requester and registers each byte.
- Drives the serializer's `data`/`send_en` and sequences on its `tx_busy`/`tx_done`.
- Holds the grant until a byte marked `last` has been fully transmitted.

---
 rtl/uart_ctrl_pkg.sv | 17 +
 rtl/uart_rr_pick.sv | 33 +++
 rtl/uart_tx_arbiter.sv | 142 ++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_ctrl_pkg.sv
// Shared types and defaults for controllers that multiplex byte streams onto one uart_tx.
// States, byte width and default sizing live here so sibling controllers agree on them.
package uart_ctrl_pkg;

  localparam int BYTE_W               = 8;
  localparam int NUM_REQ_DEFAULT      = 4;
  localparam int HOLD_TIMEOUT_DEFAULT = 1024;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    START,
    WAIT_BUSY,
    WAIT_DONE
  } arb_state_t;

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker: first set bit of req at or above ptr, wrapping to bit 0.
// Kept standalone so other shared-UART controllers can reuse the same fairness rule.
module uart_rr_pick
  import uart_ctrl_pkg::*;
#(
  parameter int N     = NUM_REQ_DEFAULT,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  // Scan offsets from farthest to nearest so the closest candidate to ptr wins.
  always_comb begin : pick
    int                pos;
    logic [IDX_W-1:0]  cand;
    idx  = '0;
    any  = 1'b0;
    pos  = 0;
    cand = '0;
    for (int k = N - 1; k >= 0; k--) begin
      pos  = (int'(ptr) + k) % N;
      cand = IDX_W'(pos);
      if (req[cand]) begin
        idx = cand;
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-locked round-robin arbiter sharing one uart_tx serializer among NUM_REQ byte streams.
// The grant is held from the first byte until the byte marked last has finished transmitting.
module uart_tx_arbiter
  import uart_ctrl_pkg::*;
#(
  parameter int NUM_REQ      = NUM_REQ_DEFAULT,
  parameter int GNT_W        = $clog2(NUM_REQ),
  parameter int HOLD_TIMEOUT = HOLD_TIMEOUT_DEFAULT
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [BYTE_W*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]        req_last,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [BYTE_W-1:0]         tx_data,
  output logic                      tx_send_en,
  input  logic                      tx_busy,
  input  logic                      tx_done,
  output logic [NUM_REQ-1:0]        gnt,
  output logic                      pkt_done,
  output logic [GNT_W-1:0]          pkt_id,
  output logic                      err_timeout
);

  localparam int                HCNT_W    = $clog2(HOLD_TIMEOUT);
  localparam logic [HCNT_W-1:0] HOLD_LAST = HCNT_W'(HOLD_TIMEOUT - 1);
  localparam logic [GNT_W-1:0]  LAST_IDX  = GNT_W'(NUM_REQ - 1);

  arb_state_t          state, state_next;
  logic [GNT_W-1:0]    rr_ptr, gnt_idx, gnt_idx_inc, pick_idx;
  logic                pick_any;
  logic [HCNT_W-1:0]   hold_cnt;
  logic                last_q;
  logic                accept;
  logic                sel_valid, sel_last;
  logic [BYTE_W-1:0]   sel_byte;

  uart_rr_pick #(
    .N     (NUM_REQ),
    .IDX_W (GNT_W)
  ) u_pick (
    .req (req_valid),
    .ptr (rr_ptr),
    .idx (pick_idx),
    .any (pick_any)
  );

  assign gnt_idx_inc = (gnt_idx == LAST_IDX) ? '0 : gnt_idx + 1'b1;

  // Only the locked owner's lane is ever looked at; everyone else is invisible while locked.
  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_byte  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_idx == GNT_W'(i)) begin
        sel_valid = req_valid[i];
        sel_last  = req_last[i];
        sel_byte  = req_data[i*BYTE_W +: BYTE_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next  = state;
    req_ready   = '0;
    gnt         = '0;
    tx_send_en  = 1'b0;
    pkt_done    = 1'b0;
    pkt_id      = '0;
    err_timeout = 1'b0;
    accept      = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      gnt[i] = (state != IDLE) && (gnt_idx == GNT_W'(i));
    end
    case (state)
      IDLE: begin
        if (pick_any) state_next = FETCH;
      end
      FETCH: begin
        for (int i = 0; i < NUM_REQ; i++) begin
          req_ready[i] = (gnt_idx == GNT_W'(i)) && req_valid[i];
        end
        accept = sel_valid;
        if (sel_valid) begin
          state_next = START;
        end else if (hold_cnt == HOLD_LAST) begin
          err_timeout = 1'b1;
          pkt_id      = gnt_idx;
          state_next  = IDLE;
        end
      end
      START: begin
        tx_send_en = 1'b1;
        state_next = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (tx_busy) state_next = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (tx_done) begin
          if (last_q) begin
            pkt_done   = 1'b1;
            pkt_id     = gnt_idx;
            state_next = IDLE;
          end else begin
            state_next = FETCH;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Pointer advances past the owner on either release so a stalled requester cannot hog the UART.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr   <= '0;
      gnt_idx  <= '0;
      tx_data  <= '0;
      hold_cnt <= '0;
      last_q   <= 1'b0;
    end else begin
      if (state == IDLE && pick_any) gnt_idx <= pick_idx;
      if (accept) begin
        tx_data  <= sel_byte;
        last_q   <= sel_last;
        hold_cnt <= '0;
      end else if (state == FETCH) begin
        hold_cnt <= err_timeout ? '0 : hold_cnt + 1'b1;
      end
      if (pkt_done || err_timeout) rr_ptr <= gnt_idx_inc;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: queue-based requesters, a uart_tx behavioural model,
// and a packet-level round-robin reference model that predicts every byte and packet event.
module tb_uart_tx_arbiter;

  localparam int NREQ = 4;
  localparam int GW   = 2;
  localparam int HOLD = 16;
  localparam int HALF = 5;

  localparam logic [1:0] EV_BYTE    = 2'd0;
  localparam logic [1:0] EV_DONE    = 2'd1;
  localparam logic [1:0] EV_TIMEOUT = 2'd2;

  typedef struct packed {
    logic [1:0]    kind;
    logic [GW-1:0] req;
    logic [7:0]    data;
  } ev_t;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [NREQ-1:0]     req_valid, req_last, req_ready, gnt;
  logic [8*NREQ-1:0]   req_data;
  logic [7:0]          tx_data;
  logic                tx_send_en, tx_busy, tx_done, pkt_done, err_timeout;
  logic [GW-1:0]       pkt_id;

  int   n_checks = 0;
  int   n_errors = 0;

  logic [8:0] drv_q [NREQ][$];
  logic [8:0] mdl_q [NREQ][$];
  ev_t        exp_q [$];
  int         model_ptr = 0;

  bit accept_seen = 0;
  bit ser_active = 0;
  bit early_mode = 0;
  int ser_len_min = 2;
  int ser_len_max = 5;
  int send_count = 0;
  int cyc = 0;
  int done_cycle = 0;
  bit expect_gnt_clear = 0;
  bit prev_send = 0;

  uart_tx_arbiter #(
    .NUM_REQ      (NREQ),
    .GNT_W        (GW),
    .HOLD_TIMEOUT (HOLD)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_last    (req_last),
    .req_ready   (req_ready),
    .tx_data     (tx_data),
    .tx_send_en  (tx_send_en),
    .tx_busy     (tx_busy),
    .tx_done     (tx_done),
    .gnt         (gnt),
    .pkt_done    (pkt_done),
    .pkt_id      (pkt_id),
    .err_timeout (err_timeout)
  );

  always #HALF clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic expect_event(input logic [1:0] kind, input string name);
    ev_t e;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("[TB] FAIL %s: got unexpected event, expected none pending (t=%0t)", name, $time);
    end else begin
      e = exp_q.pop_front();
      check_output({name, "_kind"}, 32'(kind), 32'(e.kind));
      if (kind == EV_BYTE) begin
        check_output("tx_data_at_send", 32'(tx_data), 32'(e.data));
        check_output("gnt_owner", 32'(gnt), 32'(1) << e.req);
      end else begin
        check_output({name, "_id"}, 32'(pkt_id), 32'(e.req));
      end
    end
  endtask

  // Packet-level reference: serve whole packets round-robin from the pointer among pending requesters.
  task automatic run_model();
    int   p, sel;
    bit   found, fin;
    logic [8:0] b;
    ev_t  e;
    p = model_ptr;
    forever begin
      found = 0;
      sel   = 0;
      for (int k = 0; k < NREQ; k++) begin
        if (!found && mdl_q[(p + k) % NREQ].size() > 0) begin
          found = 1;
          sel   = (p + k) % NREQ;
        end
      end
      if (!found) break;
      fin = 0;
      while (!fin && mdl_q[sel].size() > 0) begin
        b      = mdl_q[sel].pop_front();
        e.kind = EV_BYTE;
        e.req  = GW'(sel);
        e.data = b[7:0];
        exp_q.push_back(e);
        fin = b[8];
      end
      e.kind = fin ? EV_DONE : EV_TIMEOUT;
      e.req  = GW'(sel);
      e.data = 8'h00;
      exp_q.push_back(e);
      p = (sel + 1) % NREQ;
    end
    model_ptr = p;
  endtask

  task automatic push_byte(input int r, input logic [7:0] d, input bit last);
    drv_q[r].push_back({last, d});
    mdl_q[r].push_back({last, d});
  endtask

  task automatic push_packet(input int r, input int len, input bit truncated);
    for (int b = 0; b < len; b++) push_byte(r, 8'($urandom), (b == len - 1) && !truncated);
  endtask

  task automatic sync_stim();
    @(posedge clk);
    #2;
  endtask

  task automatic apply_stimulus_reset(input int cycles);
    sync_stim();
    rst = 1'b1;
    for (int i = 0; i < NREQ; i++) begin
      drv_q[i].delete();
      mdl_q[i].delete();
    end
    exp_q.delete();
    model_ptr = 0;
    repeat (cycles) @(posedge clk);
    #1;
    check_output("rst_gnt", 32'(gnt), 0);
    check_output("rst_req_ready", 32'(req_ready), 0);
    check_output("rst_tx_send_en", 32'(tx_send_en), 0);
    check_output("rst_pkt_done", 32'(pkt_done), 0);
    check_output("rst_err_timeout", 32'(err_timeout), 0);
    check_output("rst_pkt_id", 32'(pkt_id), 0);
    check_output("rst_tx_data", 32'(tx_data), 0);
    #1;
    rst = 1'b0;
  endtask

  task automatic wait_sends(input int target, input int budget);
    int n = 0;
    while (send_count < target && n < budget) begin
      @(posedge clk);
      n++;
    end
    n_checks++;
    if (send_count < target) begin
      n_errors++;
      $display("[TB] FAIL wait_sends: got %0d send_en pulses, expected %0d", send_count, target);
    end
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    bit pending;
    do begin
      @(posedge clk);
      n++;
      pending = (exp_q.size() != 0) || ser_active;
      for (int i = 0; i < NREQ; i++) pending |= (drv_q[i].size() != 0);
    end while (pending && n < budget);
    n_checks++;
    if (pending) begin
      n_errors++;
      $display("[TB] FAIL %s drain: got %0d events outstanding after %0d cycles, expected 0",
               name, exp_q.size(), n);
      exp_q.delete();
      for (int i = 0; i < NREQ; i++) begin
        drv_q[i].delete();
        mdl_q[i].delete();
      end
    end
    repeat (2) @(posedge clk);
  endtask

  // Requester driver: present queue heads at negedge, retire them on a handshake just before posedge.
  initial begin : driver
    logic [NREQ-1:0] hs;
    logic [8:0]      head;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < NREQ; i++) begin
        if (drv_q[i].size() > 0) begin
          head                 = drv_q[i][0];
          req_valid[i]         = 1'b1;
          req_data[8*i +: 8]   = head[7:0];
          req_last[i]          = head[8];
        end else begin
          req_valid[i]         = 1'b0;
          req_data[8*i +: 8]   = 8'h00;
          req_last[i]          = 1'b0;
        end
      end
      #(HALF - 1);
      hs = req_valid & req_ready;
      if (!rst) begin
        for (int i = 0; i < NREQ; i++) begin
          if (hs[i] && drv_q[i].size() > 0) begin
            void'(drv_q[i].pop_front());
            accept_seen = 1;
          end
        end
      end
    end
  end

  // uart_tx stand-in; early_mode delays busy and fires a stray tx_done while busy is still low.
  initial begin : serializer
    logic [7:0] frame_byte;
    int extra, total;
    bit aborted;
    tx_busy = 1'b0;
    tx_done = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst && tx_send_en) begin
        frame_byte = tx_data;
        ser_active = 1;
        aborted    = 0;
        extra      = early_mode ? int'($urandom_range(1, 3)) : 0;
        total      = extra + int'($urandom_range(ser_len_min, ser_len_max));
        for (int k = 1; k <= total && !aborted; k++) begin
          @(posedge clk);
          #1;
          if (rst) begin
            aborted = 1;
            tx_busy = 1'b0;
            tx_done = 1'b0;
          end else begin
            check_output("no_send_while_framing", 32'(tx_send_en), 0);
            tx_busy = (k > extra);
            tx_done = (extra > 0 && k == 1) || (k == total);
            if (k > extra) check_output("tx_data_stable", 32'(tx_data), 32'(frame_byte));
          end
        end
        if (!aborted) begin
          @(posedge clk);
          #1;
          tx_busy = 1'b0;
          tx_done = 1'b0;
        end
        ser_active = 0;
      end
    end
  end

  initial begin : monitor
    forever begin
      @(posedge clk);
      #3;
      cyc++;
      if (rst) begin
        prev_send        = 0;
        expect_gnt_clear = 0;
        accept_seen      = 0;
      end else begin
        if (expect_gnt_clear) begin
          check_output("gnt_cleared", 32'(gnt), 0);
          expect_gnt_clear = 0;
        end
        if (tx_send_en || accept_seen)
          check_output("send_after_accept", 32'(tx_send_en), 32'(accept_seen));
        accept_seen = 0;
        if (tx_send_en) begin
          check_output("send_en_gap", 32'(prev_send), 0);
          send_count++;
          expect_event(EV_BYTE, "byte");
        end
        if (pkt_done) begin
          expect_event(EV_DONE, "pkt_done");
          expect_gnt_clear = 1;
        end
        if (err_timeout) begin
          expect_event(EV_TIMEOUT, "timeout");
          check_output("timeout_latency", 32'(cyc - done_cycle), HOLD);
          expect_gnt_clear = 1;
        end
        if (tx_done) done_cycle = cyc;
        check_output("ready_onehot0", 32'($onehot0(req_ready)), 1);
        check_output("ready_in_grant", 32'(req_ready & ~(gnt & req_valid)), 0);
        check_output("gnt_onehot0", 32'($onehot0(gnt)), 1);
        prev_send = tx_send_en;
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    int base;
    bit any;
    int np;

    apply_stimulus_reset(3);

    // Round-robin from reset: 0,2,3 then wrap check with 3 and 1 pending.
    sync_stim();
    push_packet(0, 1, 0);
    push_packet(2, 1, 0);
    push_packet(3, 1, 0);
    run_model();
    wait_drain("rr_first", 500);
    sync_stim();
    push_packet(3, 1, 0);
    push_packet(1, 1, 0);
    run_model();
    wait_drain("rr_wrap", 500);

    // Single three-byte packet, with the early tx_done serializer behaviour.
    early_mode = 1;
    sync_stim();
    push_byte(0, 8'h55, 0);
    push_byte(0, 8'hA3, 0);
    push_byte(0, 8'h0F, 1);
    run_model();
    wait_drain("single_pkt", 500);
    early_mode = 0;

    // Lock: requester 1 shows up mid-packet and must wait for requester 0 to finish.
    base = send_count;
    sync_stim();
    push_packet(0, 4, 0);
    run_model();
    wait_sends(base + 2, 500);
    sync_stim();
    push_packet(1, 2, 0);
    run_model();
    wait_drain("lock", 800);

    // Timeout: requester 2 stalls after a non-last byte; requester 3 is served after release.
    sync_stim();
    push_packet(2, 1, 1);
    push_packet(3, 2, 0);
    run_model();
    wait_drain("timeout", 800);

    // Reset while a byte is in flight, then a clean packet from requester 1.
    ser_len_min = 12;
    ser_len_max = 12;
    base = send_count;
    sync_stim();
    push_packet(0, 3, 0);
    run_model();
    wait_sends(base + 2, 500);
    repeat (4) @(posedge clk);
    apply_stimulus_reset(1);
    sync_stim();
    push_packet(1, 2, 0);
    run_model();
    wait_drain("post_reset", 800);
    ser_len_min = 2;
    ser_len_max = 5;

    // Randomised batches: several requesters, multi-packet queues, occasional stalls.
    for (int bt = 0; bt < 25; bt++) begin
      early_mode = ($urandom_range(0, 1) == 1);
      sync_stim();
      any = 0;
      for (int r = 0; r < NREQ; r++) begin
        if ($urandom_range(0, 2) != 0) begin
          np = int'($urandom_range(1, 2));
          for (int p = 0; p < np; p++)
            push_packet(r, int'($urandom_range(1, 4)),
                        (p == np - 1) && ($urandom_range(0, 5) == 0));
          any = 1;
        end
      end
      if (!any) push_packet(int'($urandom_range(0, NREQ - 1)), 2, 0);
      run_model();
      wait_drain("random_batch", 3000);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
